// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the MM:SS clock control front-end.
//   - state_t            : RUN / PAUSE control state
//   - CLK_HZ_DEFAULT     : default input clock frequency
//   - DEBOUNCE_CYCLES_DEFAULT : default stable-cycle count for the debouncers
//   - cnt_width()        : bits needed for a counter running 0..n-1
// -----------------------------------------------------------------------------
package clock_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } state_t;

    localparam int unsigned CLK_HZ_DEFAULT          = 100_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // Width of a counter that has to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
// Two-flop synchronizer followed by a stable-count filter. The output takes
// the synchronized value once it has differed from the output for
// DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
// DEBOUNCE_CYCLES = 0 leaves only the synchronizer (output = second flop).
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   i_raw in  asynchronous raw input
//   o_db  out registered debounced (or merely synchronized) value
// -----------------------------------------------------------------------------
module debouncer
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_db
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign o_db = r_sync2;
        end else begin : g_filter
            localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] r_cnt;
            logic          r_db;

            // r_cnt counts mismatch cycles already seen; the output flips on
            // the edge that closes the DEBOUNCE_CYCLES-th mismatch cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (r_sync2 != r_db) begin
                    if (r_cnt == LAST) begin
                        r_cnt <= '0;
                        r_db  <= r_sync2;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign o_db = r_db;
        end
    endgenerate

endmodule

// File: rtl/clock_ctrl.sv
// -----------------------------------------------------------------------------
// clock_ctrl
// Control front-end for the MM:SS clock datapath: input conditioning, 1 Hz /
// 2 Hz prescaler and the RUN/PAUSE state.
// Build option: CLOCK_CTRL_DEBOUNCE_EN -- when defined the three inputs are
// debounced; when undefined only the synchronizers remain and
// DEBOUNCE_CYCLES has no effect.
// Ports:
//   clk          in  system clock
//   rst          in  synchronous active-high reset
//   btn_pause    in  raw pause pushbutton (active-high, asynchronous)
//   sw_adj       in  raw adjust switch (1 = adjust mode)
//   sw_sel       in  raw field select (1 = seconds, 0 = minutes)
//   tick_active  out one-cycle tick, 1 Hz normally, 2 Hz while adjusting
//   count_enable out RUN state and not adjusting
//   use_2hz      out debounced adjust switch
//   sel_seconds  out debounced field select
//   sel_minutes  out inverse of sel_seconds
// -----------------------------------------------------------------------------
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ          = CLK_HZ_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pause,
    input  logic sw_adj,
    input  logic sw_sel,
    output logic tick_active,
    output logic count_enable,
    output logic use_2hz,
    output logic sel_seconds,
    output logic sel_minutes
);

`ifdef CLOCK_CTRL_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    localparam int unsigned DB_LEN   = DB_EN ? DEBOUNCE_CYCLES : 0;
    localparam int unsigned HALF     = CLK_HZ / 2;
    localparam int unsigned CW       = cnt_width(HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    logic w_pause_db;
    logic w_adj_db;
    logic w_sel_db;

    debouncer #(.DEBOUNCE_CYCLES(DB_LEN)) u_db_pause (
        .clk   (clk),
        .rst   (rst),
        .i_raw (btn_pause),
        .o_db  (w_pause_db)
    );

    debouncer #(.DEBOUNCE_CYCLES(DB_LEN)) u_db_adj (
        .clk   (clk),
        .rst   (rst),
        .i_raw (sw_adj),
        .o_db  (w_adj_db)
    );

    debouncer #(.DEBOUNCE_CYCLES(DB_LEN)) u_db_sel (
        .clk   (clk),
        .rst   (rst),
        .i_raw (sw_sel),
        .o_db  (w_sel_db)
    );

    // ---------------- pause edge detect ----------------
    logic r_pause_prev;
    logic w_press;

    always_ff @(posedge clk) begin
        if (rst) r_pause_prev <= 1'b0;
        else     r_pause_prev <= w_pause_db;
    end

    assign w_press = w_pause_db & ~r_pause_prev;

    // ---------------- adjust register ----------------
    logic r_use_2hz;
    logic w_adj_chg;

    always_ff @(posedge clk) begin
        if (rst) r_use_2hz <= 1'b0;
        else     r_use_2hz <= w_adj_db;
    end

    assign w_adj_chg = w_adj_db ^ r_use_2hz;

    // ---------------- RUN/PAUSE FSM ----------------
    state_t r_state;
    state_t w_state_next;
    logic   w_count_enable_next;
    logic   r_count_enable;

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_next;
    end

    // A press is judged against the registered (old) adjust value.
    always_comb begin
        w_state_next = r_state;
        if (w_press && !r_use_2hz) begin
            w_state_next = (r_state == RUN) ? PAUSE : RUN;
        end
    end

    // Uses the debounced adjust value so count_enable moves with use_2hz.
    always_comb begin
        w_count_enable_next = (r_state == RUN) & ~w_adj_db;
    end

    always_ff @(posedge clk) begin
        if (rst) r_count_enable <= 1'b0;
        else     r_count_enable <= w_count_enable_next;
    end

    // ---------------- prescaler ----------------
    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          r_tick_pre;
    logic          r_tick;
    logic          w_strobe_2hz;
    logic          w_strobe_1hz;

    assign w_strobe_2hz = (r_cnt == CNT_LAST);
    assign w_strobe_1hz = w_strobe_2hz & r_phase;

    // Strobes pass through r_tick_pre then r_tick. An adjust change clears
    // the counter, phase and the pending pre-stage tick together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_tick_pre <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= r_tick_pre;
            if (w_adj_chg) begin
                r_cnt      <= '0;
                r_phase    <= 1'b0;
                r_tick_pre <= 1'b0;
            end else begin
                r_cnt      <= w_strobe_2hz ? '0 : r_cnt + CW'(1);
                r_phase    <= r_phase ^ w_strobe_2hz;
                r_tick_pre <= r_use_2hz ? w_strobe_2hz : w_strobe_1hz;
            end
        end
    end

    assign tick_active  = r_tick;
    assign count_enable = r_count_enable;
    assign use_2hz      = r_use_2hz;
    assign sel_seconds  = w_sel_db;
    assign sel_minutes  = ~w_sel_db;

endmodule
